// File: rtl/complex_int_rr_skid_stage_pkg.sv
// Shared types for the complex-integer register-read stage: op types, buffered entry and flush-range decode.
package complex_rr_pkg;

  localparam int RR_PREG_W   = 7;
  localparam int RR_AL_PTR_W = 6;

  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,
    OP_DIV  = 2'd1,
    OP_REM  = 2'd2,
    OP_RSVD = 2'd3
  } op_type_e;

  typedef struct packed {
    logic [RR_PREG_W-1:0]   src_a;
    logic [RR_PREG_W-1:0]   src_b;
    logic [RR_PREG_W-1:0]   dst;
    logic                   write_reg;
    op_type_e               op_type;
    logic [RR_AL_PTR_W-1:0] al_ptr;
    logic                   replay;
  } rr_entry_t;

  // [head, tail) on a circular pointer space; head==tail is empty unless flush_all.
  function automatic logic in_flush_range(input logic [RR_AL_PTR_W-1:0] p,
                                          input logic [RR_AL_PTR_W-1:0] head,
                                          input logic [RR_AL_PTR_W-1:0] tail,
                                          input logic req, input logic all);
    logic hit;
    if (head < tail)      hit = (p >= head) && (p < tail);
    else if (head > tail) hit = (p >= head) || (p < tail);
    else                  hit = 1'b0;
    return req && (all || hit);
  endfunction

  function automatic logic is_div(input op_type_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/complex_int_rr_skid_stage_if.sv
// Issue/execute/register-file/flush bundle of the complex register-read stage.
interface complex_int_rr_skid_stage_if #(
  parameter int LANES    = 2,
  parameter int PREG_W   = 7,
  parameter int DATA_W   = 32,
  parameter int AL_PTR_W = 6
);
  logic [LANES-1:0]               in_valid, in_ready, in_write_reg, in_replay;
  logic [LANES-1:0][PREG_W-1:0]   in_src_a, in_src_b, in_dst;
  logic [LANES-1:0][1:0]          in_op_type;
  logic [LANES-1:0][AL_PTR_W-1:0] in_al_ptr;
  logic [LANES-1:0][PREG_W-1:0]   rf_src_a, rf_src_b;
  logic [LANES-1:0][DATA_W-1:0]   rf_data_a, rf_data_b;
  logic [LANES-1:0]               out_valid, out_ready, out_write_reg, out_replay;
  logic [LANES-1:0][DATA_W-1:0]   out_operand_a, out_operand_b;
  logic [LANES-1:0][PREG_W-1:0]   out_dst;
  logic [LANES-1:0][1:0]          out_op_type;
  logic [LANES-1:0][AL_PTR_W-1:0] out_al_ptr;
  logic                           flush_req, flush_all;
  logic [AL_PTR_W-1:0]            flush_head, flush_tail;
  logic [LANES-1:0][1:0]          div_cancel_cnt;

  modport slave (
    input  in_valid, in_src_a, in_src_b, in_dst, in_write_reg, in_op_type, in_al_ptr, in_replay,
    input  rf_data_a, rf_data_b, out_ready, flush_req, flush_all, flush_head, flush_tail,
    output in_ready, rf_src_a, rf_src_b, out_valid, out_operand_a, out_operand_b, out_dst,
    output out_write_reg, out_op_type, out_al_ptr, out_replay, div_cancel_cnt
  );

  modport master (
    output in_valid, in_src_a, in_src_b, in_dst, in_write_reg, in_op_type, in_al_ptr, in_replay,
    output rf_data_a, rf_data_b, out_ready, flush_req, flush_all, flush_head, flush_tail,
    input  in_ready, rf_src_a, rf_src_b, out_valid, out_operand_a, out_operand_b, out_dst,
    input  out_write_reg, out_op_type, out_al_ptr, out_replay, div_cancel_cnt
  );
endinterface

// File: rtl/complex_int_rr_skid_stage_lane_fifo.sv
// One lane: 2-entry skid FIFO with selective flush, auto-pop of flushed heads and DIV/REM cancel count.
// RSD_RR_PERF_COUNTER_EN adds a per-cycle flushed-op count output.
module complex_rr_lane_fifo
  import complex_rr_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  rr_entry_t              in_ent,
  output logic                   in_ready,
  output rr_entry_t              head_ent,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush_req,
  input  logic                   flush_all,
  input  logic [RR_AL_PTR_W-1:0] flush_head,
  input  logic [RR_AL_PTR_W-1:0] flush_tail,
  output logic [1:0]             div_cancel_cnt
`ifdef RSD_RR_PERF_COUNTER_EN
  ,
  output logic [1:0]             flushed_cnt
`endif
);

  rr_entry_t [1:0] ent_q, ent_d;
  logic [1:0]      vld_q, vld_d;
  logic            head_q, head_d, tail_q, tail_d;
  logic [1:0]      cnt_q, cnt_d, div_q, div_d;
  logic [1:0]      ent_hit;
  logic            in_hit, enq, deq;

  always_comb begin
    for (int i = 0; i < 2; i++)
      ent_hit[i] = vld_q[i] && in_flush_range(ent_q[i].al_ptr, flush_head, flush_tail, flush_req, flush_all);
    in_hit    = in_valid && in_flush_range(in_ent.al_ptr, flush_head, flush_tail, flush_req, flush_all);
    in_ready  = (cnt_q != 2'd2);
    head_ent  = ent_q[head_q];
    out_valid = (cnt_q != 2'd0) && vld_q[head_q] && !ent_hit[head_q];
    // Dead heads drain one per cycle without being offered to execute.
    deq       = (cnt_q != 2'd0) && ((out_valid && out_ready) || !vld_q[head_q]);
    enq       = in_valid && in_ready && !in_hit;

    vld_d  = vld_q & ~ent_hit;
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    if (deq) begin
      vld_d[head_q] = 1'b0;
      head_d        = ~head_q;
    end
    if (enq) begin
      vld_d[tail_q] = 1'b1;
      ent_d[tail_q] = in_ent;
      tail_d        = ~tail_q;
    end
    cnt_d = cnt_q + {1'b0, enq} - {1'b0, deq};

    div_d = 2'(in_hit && is_div(in_ent.op_type));
    for (int i = 0; i < 2; i++)
      div_d = div_d + 2'(ent_hit[i] && is_div(ent_q[i].op_type));
  end

  assign div_cancel_cnt = div_q;

`ifdef RSD_RR_PERF_COUNTER_EN
  assign flushed_cnt = 2'(in_hit) + 2'(ent_hit[0]) + 2'(ent_hit[1]);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q  <= '0;
      vld_q  <= '0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= '0;
      div_q  <= '0;
    end else begin
      ent_q  <= ent_d;
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
    end
  end

endmodule

// File: rtl/complex_int_rr_skid_stage.sv
// Complex-integer register-read stage: LANES independent skid FIFOs between issue and execute.
// RSD_RR_PERF_COUNTER_EN adds saturating stall / flushed-op performance counters.
module complex_int_rr_skid_stage
  import complex_rr_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int PREG_W   = RR_PREG_W,
  parameter int DATA_W   = 32,
  parameter int AL_PTR_W = RR_AL_PTR_W
) (
  input  logic clk,
  input  logic rst,
  complex_int_rr_skid_stage_if.slave bus
`ifdef RSD_RR_PERF_COUNTER_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushed_ops
`endif
);

`ifdef RSD_RR_PERF_COUNTER_EN
  logic [LANES-1:0][1:0] lane_flushed;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    rr_entry_t in_ent, head_ent;
    logic      ov;

    assign in_ent = '{src_a:     bus.in_src_a[l],
                      src_b:     bus.in_src_b[l],
                      dst:       bus.in_dst[l],
                      write_reg: bus.in_write_reg[l],
                      op_type:   op_type_e'(bus.in_op_type[l]),
                      al_ptr:    bus.in_al_ptr[l],
                      replay:    bus.in_replay[l]};

    complex_rr_lane_fifo u_fifo (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (bus.in_valid[l]),
      .in_ent         (in_ent),
      .in_ready       (bus.in_ready[l]),
      .head_ent       (head_ent),
      .out_valid      (ov),
      .out_ready      (bus.out_ready[l]),
      .flush_req      (bus.flush_req),
      .flush_all      (bus.flush_all),
      .flush_head     (bus.flush_head),
      .flush_tail     (bus.flush_tail),
      .div_cancel_cnt (bus.div_cancel_cnt[l])
`ifdef RSD_RR_PERF_COUNTER_EN
      ,
      .flushed_cnt    (lane_flushed[l])
`endif
    );

    // Operands are re-read every cycle so a waiting op never holds stale data.
    assign bus.rf_src_a[l]      = PREG_W'(head_ent.src_a);
    assign bus.rf_src_b[l]      = PREG_W'(head_ent.src_b);
    assign bus.out_operand_a[l] = DATA_W'(bus.rf_data_a[l]);
    assign bus.out_operand_b[l] = DATA_W'(bus.rf_data_b[l]);
    assign bus.out_valid[l]     = ov;
    assign bus.out_dst[l]       = PREG_W'(head_ent.dst);
    assign bus.out_write_reg[l] = ov && head_ent.write_reg;
    assign bus.out_op_type[l]   = head_ent.op_type;
    assign bus.out_al_ptr[l]    = AL_PTR_W'(head_ent.al_ptr);
    assign bus.out_replay[l]    = head_ent.replay;
  end

`ifdef RSD_RR_PERF_COUNTER_EN
  logic [31:0] stall_q, stall_d, flushed_q, flushed_d;
  logic [32:0] flushed_sum;

  always_comb begin
    flushed_sum = {1'b0, flushed_q};
    for (int l = 0; l < LANES; l++)
      flushed_sum = flushed_sum + 33'(lane_flushed[l]);
    flushed_d = flushed_sum[32] ? '1 : flushed_sum[31:0];
    stall_d   = stall_q;
    if ((|(bus.out_valid & ~bus.out_ready)) && (stall_q != '1))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q   <= '0;
      flushed_q <= '0;
    end else begin
      stall_q   <= stall_d;
      flushed_q <= flushed_d;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_flushed_ops  = flushed_q;
`endif

endmodule

// File: tb/tb_complex_int_rr_skid_stage.sv
// Directed bench for the complex register-read skid stage; register file modelled as a pure function of index.
module tb_complex_int_rr_skid_stage;
  import complex_rr_pkg::*;

  localparam int LANES = 2, PREG_W = 7, DATA_W = 32, AL_PTR_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  complex_int_rr_skid_stage_if #(.LANES(LANES), .PREG_W(PREG_W), .DATA_W(DATA_W), .AL_PTR_W(AL_PTR_W)) bus ();

`ifdef RSD_RR_PERF_COUNTER_EN
  logic [31:0] perf_stall_cycles, perf_flushed_ops;
`endif

  complex_int_rr_skid_stage #(.LANES(LANES), .PREG_W(PREG_W), .DATA_W(DATA_W), .AL_PTR_W(AL_PTR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RSD_RR_PERF_COUNTER_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushed_ops  (perf_flushed_ops)
`endif
  );

  function automatic logic [31:0] rf_val(input logic [6:0] idx);
    return (idx == 7'd5) ? 32'h0000_1234 : {25'h140_0000, idx};
  endfunction

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      bus.rf_data_a[l] = rf_val(bus.rf_src_a[l]);
      bus.rf_data_b[l] = rf_val(bus.rf_src_b[l]);
    end
  end

  task automatic idle();
    bus.in_valid = '0; bus.in_src_a = '0; bus.in_src_b = '0; bus.in_dst = '0;
    bus.in_write_reg = '0; bus.in_op_type = '0; bus.in_al_ptr = '0; bus.in_replay = '0;
    bus.out_ready = '1; bus.flush_req = 1'b0; bus.flush_all = 1'b0;
    bus.flush_head = '0; bus.flush_tail = '0;
  endtask

  task automatic set_op(input int l, input logic [1:0] op, input logic [6:0] sa,
                        input logic [6:0] dst, input logic [5:0] al);
    bus.in_valid[l] = 1'b1; bus.in_src_a[l] = sa; bus.in_src_b[l] = sa + 7'd1;
    bus.in_dst[l] = dst; bus.in_write_reg[l] = 1'b1; bus.in_op_type[l] = op;
    bus.in_al_ptr[l] = al; bus.in_replay[l] = al[0];
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    #3;
    vectors++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid: got %b want 00", bus.out_valid); end
    vectors++; if (bus.div_cancel_cnt !== 4'b0000) begin errors++; $display("FAIL reset_div_cnt: got %b want 0000", bus.div_cancel_cnt); end
    @(negedge clk); rst = 1'b1;
    step();
    vectors++; if (bus.in_ready !== 2'b11) begin errors++; $display("FAIL reset_in_ready: got %b want 11", bus.in_ready); end
  endtask

  task automatic test_single();
    set_op(0, 2'd0, 7'd5, 7'd20, 6'd1); #1;
    vectors++; if (bus.out_valid[0] !== 1'b0) begin errors++; $display("FAIL single_pre_valid: got %b want 0", bus.out_valid[0]); end
    step(); bus.in_valid = '0; #1;
    vectors++; if (bus.out_valid[0] !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.out_valid[0]); end
    vectors++; if (bus.out_operand_a[0] !== 32'h1234) begin errors++; $display("FAIL single_opa: got %h want 00001234", bus.out_operand_a[0]); end
    vectors++; if (bus.in_ready !== 2'b11) begin errors++; $display("FAIL single_in_ready: got %b want 11", bus.in_ready); end
    vectors++; if ({bus.out_dst[0], bus.out_write_reg[0]} !== {7'd20, 1'b1}) begin errors++; $display("FAIL single_dst: got %0d/%b want 20/1", bus.out_dst[0], bus.out_write_reg[0]); end
    step();
    vectors++; if (bus.out_valid[0] !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", bus.out_valid[0]); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready[0] = 1'b0;
    set_op(0, 2'd0, 7'd1, 7'd11, 6'd1); #1;
    vectors++; if (bus.in_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_rdy0: got %b want 1", bus.in_ready[0]); end
    step();
    set_op(0, 2'd0, 7'd2, 7'd12, 6'd2); #1;
    vectors++; if ({bus.out_valid[0], bus.out_dst[0]} !== {1'b1, 7'd11}) begin errors++; $display("FAIL b2b_hold_head: got %b/%0d want 1/11", bus.out_valid[0], bus.out_dst[0]); end
    step();
    set_op(0, 2'd0, 7'd3, 7'd13, 6'd3); #1;
    vectors++; if (bus.in_ready[0] !== 1'b0) begin errors++; $display("FAIL b2b_full: got %b want 0", bus.in_ready[0]); end
    step();
    vectors++; if (bus.in_ready[0] !== 1'b0) begin errors++; $display("FAIL b2b_still_full: got %b want 0", bus.in_ready[0]); end
    bus.out_ready[0] = 1'b1; #1;
    vectors++; if ({bus.out_valid[0], bus.out_dst[0]} !== {1'b1, 7'd11}) begin errors++; $display("FAIL b2b_out1: got %b/%0d want 1/11", bus.out_valid[0], bus.out_dst[0]); end
    step();
    vectors++; if ({bus.out_valid[0], bus.out_dst[0], bus.in_ready[0]} !== {1'b1, 7'd12, 1'b1}) begin errors++; $display("FAIL b2b_out2: got %b/%0d/%b want 1/12/1", bus.out_valid[0], bus.out_dst[0], bus.in_ready[0]); end
    step(); bus.in_valid = '0; #1;
    vectors++; if ({bus.out_valid[0], bus.out_dst[0]} !== {1'b1, 7'd13}) begin errors++; $display("FAIL b2b_out3: got %b/%0d want 1/13", bus.out_valid[0], bus.out_dst[0]); end
    vectors++; if (bus.out_operand_a[0] !== 32'hA000_0003) begin errors++; $display("FAIL b2b_opa3: got %h want a0000003", bus.out_operand_a[0]); end
    step();
    vectors++; if (bus.out_valid[0] !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", bus.out_valid[0]); end
  endtask

  task automatic test_wrap_flush();
    idle(); bus.out_ready[0] = 1'b0;
    set_op(0, 2'd1, 7'd8, 7'd30, 6'd60); step();
    set_op(0, 2'd0, 7'd9, 7'd31, 6'd2); step();
    bus.in_valid = '0; bus.flush_req = 1'b1; bus.flush_head = 6'd58; bus.flush_tail = 6'd3; #1;
    vectors++; if (bus.out_valid[0] !== 1'b0) begin errors++; $display("FAIL wrap_mask: got %b want 0", bus.out_valid[0]); end
    step(); bus.flush_req = 1'b0; #1;
    vectors++; if (bus.div_cancel_cnt[0] !== 2'd1) begin errors++; $display("FAIL wrap_div_cnt: got %0d want 1", bus.div_cancel_cnt[0]); end
    vectors++; if (bus.out_valid[0] !== 1'b0) begin errors++; $display("FAIL wrap_no_valid: got %b want 0", bus.out_valid[0]); end
    step();
    vectors++; if ({bus.in_ready[0], bus.out_valid[0], bus.div_cancel_cnt[0]} !== {1'b1, 1'b0, 2'd0}) begin errors++; $display("FAIL wrap_pop1: got %b/%b/%0d want 1/0/0", bus.in_ready[0], bus.out_valid[0], bus.div_cancel_cnt[0]); end
    step();
    vectors++; if (bus.out_valid[0] !== 1'b0) begin errors++; $display("FAIL wrap_pop2: got %b want 0", bus.out_valid[0]); end
    bus.out_ready[0] = 1'b1;
    set_op(0, 2'd0, 7'd4, 7'd33, 6'd5); step(); bus.in_valid = '0; #1;
    vectors++; if ({bus.out_valid[0], bus.out_dst[0]} !== {1'b1, 7'd33}) begin errors++; $display("FAIL wrap_refill: got %b/%0d want 1/33", bus.out_valid[0], bus.out_dst[0]); end
    step();
  endtask

  task automatic test_equal_range();
    idle(); bus.out_ready[0] = 1'b0;
    set_op(0, 2'd1, 7'd6, 7'd40, 6'd10); step();
    bus.in_valid = '0; bus.flush_req = 1'b1; bus.flush_head = 6'd10; bus.flush_tail = 6'd10; #1;
    vectors++; if (bus.out_valid[0] !== 1'b1) begin errors++; $display("FAIL eq_no_mask: got %b want 1", bus.out_valid[0]); end
    step(); bus.flush_req = 1'b0; #1;
    vectors++; if ({bus.out_valid[0], bus.div_cancel_cnt[0]} !== {1'b1, 2'd0}) begin errors++; $display("FAIL eq_kept: got %b/%0d want 1/0", bus.out_valid[0], bus.div_cancel_cnt[0]); end
    bus.flush_req = 1'b1; bus.flush_all = 1'b1; #1;
    vectors++; if (bus.out_valid[0] !== 1'b0) begin errors++; $display("FAIL all_mask: got %b want 0", bus.out_valid[0]); end
    step(); bus.flush_req = 1'b0; bus.flush_all = 1'b0; #1;
    vectors++; if ({bus.out_valid[0], bus.div_cancel_cnt[0]} !== {1'b0, 2'd1}) begin errors++; $display("FAIL all_dropped: got %b/%0d want 0/1", bus.out_valid[0], bus.div_cancel_cnt[0]); end
    step(); bus.out_ready[0] = 1'b1;
  endtask

  task automatic test_incoming_rem();
    idle(); bus.out_ready[0] = 1'b0;
    set_op(0, 2'd1, 7'd10, 7'd50, 6'd20); set_op(1, 2'd0, 7'd20, 7'd41, 6'd40); step();
    set_op(0, 2'd1, 7'd11, 7'd51, 6'd21); set_op(1, 2'd0, 7'd21, 7'd42, 6'd41); #1;
    vectors++; if ({bus.out_valid[1], bus.out_dst[1]} !== {1'b1, 7'd41}) begin errors++; $display("FAIL rem_l1_a: got %b/%0d want 1/41", bus.out_valid[1], bus.out_dst[1]); end
    step();
    set_op(0, 2'd2, 7'd12, 7'd52, 6'd22); set_op(1, 2'd0, 7'd22, 7'd43, 6'd42);
    bus.flush_req = 1'b1; bus.flush_head = 6'd20; bus.flush_tail = 6'd25; #1;
    vectors++; if ({bus.out_valid[1], bus.out_dst[1]} !== {1'b1, 7'd42}) begin errors++; $display("FAIL rem_l1_b: got %b/%0d want 1/42", bus.out_valid[1], bus.out_dst[1]); end
    vectors++; if (bus.out_valid[0] !== 1'b0) begin errors++; $display("FAIL rem_l0_mask: got %b want 0", bus.out_valid[0]); end
    step(); bus.in_valid = '0; bus.flush_req = 1'b0; #1;
    vectors++; if (bus.div_cancel_cnt !== {2'd0, 2'd3}) begin errors++; $display("FAIL rem_div_cnt: got %b want 0011", bus.div_cancel_cnt); end
    vectors++; if ({bus.out_valid[1], bus.out_dst[1]} !== {1'b1, 7'd43}) begin errors++; $display("FAIL rem_l1_c: got %b/%0d want 1/43", bus.out_valid[1], bus.out_dst[1]); end
    step(); step(); step();
    vectors++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL rem_drained: got %b want 00", bus.out_valid); end
    bus.out_ready = '1;
  endtask

  task automatic test_reset_mid();
    idle(); bus.out_ready[0] = 1'b0;
    set_op(0, 2'd0, 7'd1, 7'd60, 6'd1); step();
    set_op(0, 2'd0, 7'd2, 7'd61, 6'd2); step();
    bus.in_valid = '0; #1;
    vectors++; if ({bus.in_ready[0], bus.out_valid[0]} !== 2'b01) begin errors++; $display("FAIL rstmid_pre: got %b want 01", {bus.in_ready[0], bus.out_valid[0]}); end
    rst = 1'b0; #1;
    vectors++; if ({bus.out_valid, bus.in_ready} !== 4'b0011) begin errors++; $display("FAIL rstmid_async: got %b want 0011", {bus.out_valid, bus.in_ready}); end
    @(negedge clk); rst = 1'b1; bus.out_ready = '1;
    step();
    vectors++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL rstmid_empty: got %b want 00", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap_flush();
    test_equal_range();
    test_incoming_rem();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
